// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one one-minute timer among NUM_REQ requesters; optional TIMER_ARB_STATS_EN enables expired_count.
// Latency: grant/timer_start one edge after req is seen in IDLE; done one edge after timesup; one CLEAR cycle minimum.
// Backpressure: requesters hold req until done (dropping it aborts); requests seen outside IDLE wait for the next IDLE.
module timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               timer_start,
  input  logic               timer_timesup,
  output logic               busy,
  output logic [7:0]         expired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt, sel_idx;
  logic               sel_vld;
  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt;
  logic               start_nxt;

  // Rotate req so bit 0 is the requester just after the pointer, then take the first set bit
  always_comb begin
    req_rot = NUM_REQ'({req, req} >> (ptr + IDX_W'(1)));
    sel_vld = 1'b0;
    sel_idx = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_vld && req_rot[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'((int'(ptr) + 1 + i) % NUM_REQ);
      end
    end
  end

  // Next-state and next-output decode; the owner is the single set bit of grant
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    done_nxt  = '0;
    start_nxt = timer_start;
    case (state)
      S_IDLE: begin
        grant_nxt = '0;
        start_nxt = 1'b0;
        if (sel_vld) begin
          grant_nxt = NUM_REQ'(1) << sel_idx;
          start_nxt = 1'b1;
          ptr_nxt   = sel_idx;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Expiry takes precedence over an abort seen in the same cycle
        if (timer_timesup) begin
          done_nxt  = grant;
          grant_nxt = '0;
          start_nxt = 1'b0;
          state_nxt = S_CLEAR;
        end else if ((req & grant) == '0) begin
          grant_nxt = '0;
          start_nxt = 1'b0;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        grant_nxt = '0;
        start_nxt = 1'b0;
        // Hold here until the timer has dropped timesup
        if (!timer_timesup) state_nxt = S_IDLE;
      end
      default: begin
        grant_nxt = '0;
        start_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs; reset clears outputs without a clock edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      grant       <= '0;
      done        <= '0;
      timer_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant       <= grant_nxt;
      done        <= done_nxt;
      timer_start <= start_nxt;
      busy        <= (state_nxt != S_IDLE);
    end
  end

`ifdef TIMER_ARB_STATS_EN
  logic [7:0] expired_cnt;

  // Count completed intervals alongside the done pulse, saturating at 255
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      expired_cnt <= 8'd0;
    end else if ((done_nxt != '0) && (expired_cnt != 8'hFF)) begin
      expired_cnt <= expired_cnt + 8'd1;
    end
  end

  assign expired_count = expired_cnt;
`else
  assign expired_count = 8'd0;
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter with a behavioural one-minute timer and a grant/done scoreboard.
// Latency: timer raises timesup after 60 edges with start high and clears on an edge with start low.
// Backpressure: none; requests are driven directly on the falling edge.
module tb_timer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 3;
`ifdef TIMER_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] grant, done;
  logic               timer_start, timer_timesup, busy;
  logic [7:0]         expired_count;

  timer_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req           (req),
    .grant         (grant),
    .done          (done),
    .timer_start   (timer_start),
    .timer_timesup (timer_timesup),
    .busy          (busy),
    .expired_count (expired_count)
  );

  always #5 clock = ~clock;

  // Timer model: counts edges with start high, clears on an edge with start low
  logic [6:0] tmr_cnt = 7'd0;
  always @(posedge clock) begin
    if (timer_start) tmr_cnt <= (tmr_cnt == 7'd127) ? tmr_cnt : tmr_cnt + 7'd1;
    else             tmr_cnt <= 7'd0;
  end
  assign timer_timesup = (tmr_cnt == 7'd60);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues filled by the stimulus, drained by the monitor
  logic [NUM_REQ-1:0] exp_grant_q[$];
  logic [NUM_REQ-1:0] exp_done_q[$];
  int                 grant_cyc_q[$];
  int                 grant_cyc = 0;
  logic [NUM_REQ-1:0] prev_grant = '0;
  int                 exp_cnt = 0;

  function automatic int exp_count_val();
    return STATS_EN ? exp_cnt : 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Compare every new grant and every done pulse against the expected queues
  always @(negedge clock) begin
    if (reset_n) begin
      if (grant != '0 && prev_grant == '0) begin
        if (exp_grant_q.size() == 0) check_eq("unexpected_grant", 32'(grant), 32'd0);
        else                         check_eq("grant_owner", 32'(grant), 32'(exp_grant_q.pop_front()));
        grant_cyc = cyc;
        grant_cyc_q.push_back(cyc);
      end
      if (done != '0) begin
        if (exp_done_q.size() == 0) check_eq("unexpected_done", 32'(done), 32'd0);
        else                        check_eq("done_owner", 32'(done), 32'(exp_done_q.pop_front()));
        check_eq("done_latency", cyc - grant_cyc, 32'd61);
      end
    end
    prev_grant = grant;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (done == '0 && n < 80);
    ok = (done != '0);
  endtask

  task automatic wait_grant(output bit ok);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (grant == '0 && n < 10);
    ok = (grant != '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    tick(2);
    reset_n = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    bit ok;
    int n;
    int misses;

    // Reset values
    tick(2);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_start", 32'(timer_start), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_count", 32'(expired_count), 32'd0);
    reset_n = 1'b1;
    tick(1);

    // Single request: 61 cycles of timer_start, done, then idle
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    req = 4'b0001;
    tick(1);
    check_eq("single_grant", 32'(grant), 32'h1);
    check_eq("single_start", 32'(timer_start), 32'd1);
    check_eq("single_busy", 32'(busy), 32'd1);
    n = 0;
    while (timer_start && n < 100) begin
      n++;
      tick(1);
    end
    check_eq("single_start_len", n, 32'd61);
    exp_cnt = sat_inc(exp_cnt);
    check_eq("single_done", 32'(done), 32'h1);
    check_eq("single_grant_off", 32'(grant), 32'd0);
    check_eq("single_busy_clear", 32'(busy), 32'd1);
    check_eq("single_count", 32'(expired_count), exp_count_val());
    req = '0;
    tick(1);
    check_eq("single_idle", 32'(busy), 32'd0);
    check_eq("single_done_off", 32'(done), 32'd0);

    // Round robin from a fresh pointer with all requests held
    do_reset();
    grant_cyc_q.delete();
    exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0100); exp_grant_q.push_back(4'b1000);
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001); exp_done_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0100); exp_done_q.push_back(4'b1000);
    exp_done_q.push_back(4'b0001);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_done(ok);
      check_eq("rr_done_seen", 32'(ok), 32'd1);
      exp_cnt = sat_inc(exp_cnt);
    end
    check_eq("rr_count4", 32'(expired_count), exp_count_val());
    wait_done(ok);
    check_eq("rr_done5_seen", 32'(ok), 32'd1);
    exp_cnt = sat_inc(exp_cnt);
    req = '0;
    tick(3);
    check_eq("rr_grants", grant_cyc_q.size(), 32'd5);
    for (int k = 0; k < 4; k++) begin
      if (k + 1 < grant_cyc_q.size())
        check_eq("rr_spacing", grant_cyc_q[k+1] - grant_cyc_q[k], 32'd63);
    end

    // Abort: requester drops 20 cycles into its interval
    exp_grant_q.push_back(4'b0010);
    req = 4'b0010;
    wait_grant(ok);
    check_eq("abort_grant_seen", 32'(ok), 32'd1);
    tick(20);
    req = '0;
    tick(1);
    check_eq("abort_grant_off", 32'(grant), 32'd0);
    check_eq("abort_start_off", 32'(timer_start), 32'd0);
    check_eq("abort_no_done", 32'(done), 32'd0);
    tick(1);
    check_eq("abort_idle", 32'(busy), 32'd0);
    check_eq("abort_count", 32'(expired_count), exp_count_val());

    // Owner drops req in the same cycle timesup rises: completion wins
    exp_grant_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0100);
    req = 4'b0100;
    wait_grant(ok);
    n = 0;
    while (!timer_timesup && n < 100) begin
      tick(1);
      n++;
    end
    req = '0;
    tick(1);
    exp_cnt = sat_inc(exp_cnt);
    check_eq("simul_done", 32'(done), 32'h4);
    check_eq("simul_count", 32'(expired_count), exp_count_val());
    tick(2);

    // Asynchronous reset in the middle of an interval
    exp_grant_q.push_back(4'b0001);
    req = 4'b0001;
    wait_grant(ok);
    tick(29);
    #2;
    reset_n = 1'b0;
    req     = '0;
    #1;
    check_eq("arst_grant", 32'(grant), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_start", 32'(timer_start), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    tick(2);
    reset_n = 1'b1;
    exp_cnt = 0;
    exp_grant_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0100);
    req = 4'b0100;
    wait_grant(ok);
    check_eq("arst_regrant", 32'(grant), 32'h4);
    n = 0;
    while (!timer_timesup && n < 100) begin
      tick(1);
      n++;
    end
    check_eq("arst_full_interval", n, 32'd60);
    tick(1);
    exp_cnt = sat_inc(exp_cnt);
    check_eq("arst_done_after", 32'(done), 32'h4);
    check_eq("arst_count", 32'(expired_count), exp_count_val());
    req = '0;
    tick(2);

    // Saturation: 256 completed intervals from a single requester
    do_reset();
    for (int k = 0; k < 256; k++) begin
      exp_grant_q.push_back(4'b0001);
      exp_done_q.push_back(4'b0001);
    end
    req = 4'b0001;
    misses = 0;
    for (int k = 0; k < 256; k++) begin
      wait_done(ok);
      if (!ok) misses++;
      exp_cnt = sat_inc(exp_cnt);
      if (k == 254) check_eq("sat_count255", 32'(expired_count), exp_count_val());
    end
    req = '0;
    check_eq("sat_dones", misses, 32'd0);
    check_eq("sat_count_hold", 32'(expired_count), exp_count_val());
    tick(3);

    check_eq("sb_grants_left", exp_grant_q.size(), 32'd0);
    check_eq("sb_dones_left", exp_done_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin arbiter that shares the single one-minute `timer` block among NUM_REQ requesters. It grants one requester at a time, drives the timer's `start_timer` input, and watches `timesup`. On expiry it pulses `done` to the owner and runs a clear cycle so the timer returns to zero before the next grant. It sits between the game/control FSMs and the timer instance at the top level.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- IDX_W, 3, width of the internal grant index and pointer (≥ clog2(NUM_REQ))
- clock  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per requester; held high until `done` or voluntarily dropped (abort)
- grant  out  NUM_REQ  one-hot owner of the timer; all-zero when no owner
- done  out  NUM_REQ  one-cycle pulse to the owner when its interval expires
- timer_start  out  1  connects to the timer's start_timer
- timer_timesup  in  1  connects to the timer's timesup
- busy  out  1  high whenever state ≠ IDLE
- expired_count  out  8  completed-interval counter (see Configuration)

## Operation
- Outputs are registered. Reset values: grant=0, done=0, timer_start=0, busy=0, expired_count=0, state=IDLE, rr pointer=NUM_REQ-1 (req[0] has first priority).
- States: IDLE, RUN, CLEAR.
- IDLE: if any req bit is set, select the first set bit, searching from pointer+1 upward with wrap. Next edge: grant one-hot set, timer_start=1, pointer=selected index, state→RUN. If no req bit is set, remain in IDLE.
- RUN: hold grant and timer_start.
  - timer_timesup=1 → next edge: done[owner]=1 for one cycle, grant=0, timer_start=0, state→CLEAR.
  - Else if req[owner]=0 (abort) → next edge: grant=0, timer_start=0, no done, state→CLEAR.
  - If timesup and the owner's req drop occur in the same cycle, completion wins: done is pulsed.
  - req changes on non-owners are ignored.
- CLEAR: timer_start=0, done=0. Stay in CLEAR while timer_timesup=1. Minimum one cycle. Then state→IDLE.
- The pointer advances only on a grant, so requests held continuously are served in strict rotation.
- The arbiter never samples req in RUN or CLEAR for selection. A request arriving there waits for IDLE.

## Timing
- The timer expires on the 60th rising edge with start_timer high.
- With req[i] rising before edge E0 while IDLE:
  - grant[i] and timer_start are high after E0.
  - timer_timesup is high after E0+60.
  - done[i] is high and grant low after E0+61.
  - CLEAR occupies the cycle after E0+61.
  - IDLE after E0+62; the next grant is at the earliest after E0+63.
- Grant-to-grant period with back-to-back requesters is 63 cycles.
- Abort: grant drops one edge after req[owner] is seen low. The timer is cleared in CLEAR.
- Async reset mid-RUN: grant, done and timer_start fall immediately without waiting for a clock edge. The timer clears itself on its next edge with start_timer low.

## Configuration
- TIMER_ARB_STATS_EN defined: expired_count increments by 1 on every done pulse and saturates at 255. Aborts do not count. It is reset only by reset_n.
- TIMER_ARB_STATS_EN undefined: expired_count is tied to 0 and no counter logic is generated. All other behaviour is identical.

## Test plan
- Single request: req=4'b0001 held after reset → grant=0001 after E0, timer_start high for exactly 61 cycles, done=0001 for one cycle after E0+61, busy low after E0+62.
- Round robin: req=4'b1111 held → grants in order 0001, 0010, 0100, 1000, 0001, each spaced 63 cycles; expired_count=4 after the fourth done (with TIMER_ARB_STATS_EN).
- Abort: req=0010 only, drop req[1] 20 cycles after grant → grant falls next edge, no done pulse, timer_start low, IDLE within 2 cycles, expired_count unchanged.
- Simultaneous: drop req[owner] in the same cycle timer_timesup rises → done pulses anyway, expired_count increments.
- Reset mid-RUN: assert reset_n=0 at cycle 30 of an interval → grant/done/timer_start=0 with no clock edge; after release with req=0100, the first grant is 0100, timesup is seen after a full 60 edges, and done follows.
- Saturation (macro on): 256 completed intervals → expired_count stays at 255.
